// File: rtl/tap_tempo_decoder.sv
// tap_tempo_decoder
//   Measures the interval between rising edges of a user tap input and
//   converts it into the 3-bit speed code used by the tempo clock divider
//   (0 = 40 ... 7 = 220 nodes/min).
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   tap          raw asynchronous tap level (rising edge = tap)
//   speed        decoded speed code (registered)
//   speed_valid  one-cycle pulse when speed/period update
//   period       last accepted interval in clk cycles
//   measuring    high while an interval is being counted
//   timeout      one-cycle pulse when no tap arrives within MAX_PERIOD/SCALE
//
// Build option:
//   TAP_AVG_EN   when defined, each accepted interval after the first one is
//                averaged with the previous raw interval before classification.
module tap_tempo_decoder #(
  parameter int          SCALE         = 1,
  parameter logic [2:0]  DEFAULT_SPEED = 3'd1,
  parameter int          MIN_PERIOD    = 10000000,
  parameter int          MAX_PERIOD    = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tap,
  output logic [2:0]  speed,
  output logic        speed_valid,
  output logic [26:0] period,
  output logic        measuring,
  output logic        timeout
);

  localparam logic [26:0] MIN_CYC = 27'(MIN_PERIOD / SCALE);
  localparam logic [26:0] MAX_CYC = 27'(MAX_PERIOD / SCALE);

  // Classification thresholds; an interval equal to a threshold maps to
  // the slower code.
  localparam logic [26:0] T0 = 27'(62500000 / SCALE);
  localparam logic [26:0] T1 = 27'(43750000 / SCALE);
  localparam logic [26:0] T2 = 27'(33750000 / SCALE);
  localparam logic [26:0] T3 = 27'(27500000 / SCALE);
  localparam logic [26:0] T4 = 27'(23214286 / SCALE);
  localparam logic [26:0] T5 = 27'(19047619 / SCALE);
  localparam logic [26:0] T6 = 27'(15151516 / SCALE);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t      state;
  logic [26:0] counter;
  logic        tap_sync1;
  logic        tap_sync2;
  logic        tap_prev;
  logic        tap_edge;
  logic [26:0] p_eff;

`ifdef TAP_AVG_EN
  // Previous raw interval; zero means "no previous interval" because every
  // accepted interval is at least 1 cycle long.
  logic [26:0] p_prev;
  logic [27:0] avg_sum;
`endif

  function automatic logic [2:0] classify(input logic [26:0] p);
    if      (p >= T0) classify = 3'd0;
    else if (p >= T1) classify = 3'd1;
    else if (p >= T2) classify = 3'd2;
    else if (p >= T3) classify = 3'd3;
    else if (p >= T4) classify = 3'd4;
    else if (p >= T5) classify = 3'd5;
    else if (p >= T6) classify = 3'd6;
    else              classify = 3'd7;
  endfunction

  always_comb begin
    tap_edge = tap_sync2 & ~tap_prev;
`ifdef TAP_AVG_EN
    avg_sum = {1'b0, p_prev} + {1'b0, counter};
    if (p_prev == '0) p_eff = counter;
    else              p_eff = 27'(avg_sum >> 1);
`else
    p_eff = counter;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser flops reset high so a tap held through reset is not an edge.
      tap_sync1   <= 1'b1;
      tap_sync2   <= 1'b1;
      tap_prev    <= 1'b1;
      state       <= IDLE;
      counter     <= '0;
      speed       <= DEFAULT_SPEED;
      period      <= '0;
      speed_valid <= 1'b0;
      timeout     <= 1'b0;
      measuring   <= 1'b0;
`ifdef TAP_AVG_EN
      p_prev      <= '0;
`endif
    end else begin
      tap_sync1   <= tap;
      tap_sync2   <= tap_sync1;
      tap_prev    <= tap_sync2;
      speed_valid <= 1'b0;
      timeout     <= 1'b0;

      case (state)
        IDLE: begin
          if (tap_edge) begin
            counter   <= 27'd1;
            state     <= COUNT;
            measuring <= 1'b1;
          end
        end

        COUNT: begin
          if (tap_edge && counter >= MIN_CYC) begin
            // An edge on the MAX cycle lands here too: the edge wins.
            period      <= p_eff;
            speed       <= classify(p_eff);
            speed_valid <= 1'b1;
            counter     <= 27'd1;
`ifdef TAP_AVG_EN
            p_prev      <= counter;
`endif
          end else if (!tap_edge && counter == MAX_CYC) begin
            timeout   <= 1'b1;
            state     <= IDLE;
            measuring <= 1'b0;
            counter   <= '0;
`ifdef TAP_AVG_EN
            p_prev    <= '0;
`endif
          end else begin
            counter <= counter + 27'd1;
          end
        end

        default: begin
          state     <= IDLE;
          measuring <= 1'b0;
          counter   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_tempo_decoder.sv
// Testbench for tap_tempo_decoder. SCALE = 10000 keeps the run short:
// MIN = 1000, MAX = 10000 cycles; thresholds 6250, 4375, 3375, 2750, 2321,
// 1904, 1515. A raw tap rise driven after posedge R is seen as an edge at
// posedge R+3, so rises N cycles apart give a measured interval of N.
module tb_tap_tempo_decoder;

  localparam int SCALE = 10000;

  logic        clk = 1'b0;
  logic        reset;
  logic        tap;
  logic [2:0]  speed;
  logic        speed_valid;
  logic [26:0] period;
  logic        measuring;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;
  int sv_count = 0;
  int to_count = 0;

  tap_tempo_decoder #(
    .SCALE(SCALE),
    .DEFAULT_SPEED(3'd1),
    .MIN_PERIOD(10000000),
    .MAX_PERIOD(100000000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tap(tap),
    .speed(speed),
    .speed_valid(speed_valid),
    .period(period),
    .measuring(measuring),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (speed_valid) sv_count <= sv_count + 1;
    if (timeout)     to_count <= to_count + 1;
  end

  typedef struct {
    int interval;
    int exp_speed;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise tap for 20 cycles, then release it.
  task automatic rise_hold();
    tap = 1'b1;
    step(20);
    tap = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tap   = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);
  endtask

  int sv0;
  int to0;
  int k;
  int exp_p2, exp_s2, exp_p3, exp_s3;

  initial begin
    vecs[0] = '{6250, 0};
    vecs[1] = '{6249, 1};
    vecs[2] = '{1515, 6};
    vecs[3] = '{1514, 7};
    vecs[4] = '{1000, 7};   // exactly MIN: accepted
    vecs[5] = '{10000, 0};  // edge on the MAX cycle: accepted
    vecs[6] = '{2321, 4};
    vecs[7] = '{1904, 5};

    // Reset with tap held high.
    reset = 1'b1;
    tap   = 1'b1;
    step(2);
    check("reset speed", int'(speed), 1);
    check("reset period", int'(period), 0);
    check("reset speed_valid", int'(speed_valid), 0);
    check("reset timeout", int'(timeout), 0);
    check("reset measuring", int'(measuring), 0);
    reset = 1'b0;
    step(10);
    check("no edge after reset measuring", int'(measuring), 0);
    check("no edge after reset speed_valid count", sv_count, 0);
    tap = 1'b0;
    step(5);
    check("tap fall measuring", int'(measuring), 0);

    // Table: one interval per entry, each from a fresh reset.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      sv0 = sv_count;
      rise_hold();
      step(vecs[i].interval - 20);
      rise_hold();
      step(10);
      check($sformatf("vec%0d speed_valid pulses", i), sv_count - sv0, 1);
      check($sformatf("vec%0d period", i), int'(period), vecs[i].interval);
      check($sformatf("vec%0d speed", i), int'(speed), vecs[i].exp_speed);
      check($sformatf("vec%0d measuring", i), int'(measuring), 1);
    end

    // Bounce at +500 is ignored; interval measured from first tap.
    do_reset();
    sv0 = sv_count;
    rise_hold();
    step(500 - 20);
    rise_hold();
    step(2500 - 20);
    rise_hold();
    step(10);
    check("bounce speed_valid pulses", sv_count - sv0, 1);
    check("bounce period", int'(period), 3000);
    check("bounce speed", int'(speed), 3);

    // Continuous tapping: 5000, 3000, 2000.
`ifdef TAP_AVG_EN
    exp_p2 = 4000; exp_s2 = 2;
    exp_p3 = 2500; exp_s3 = 4;
`else
    exp_p2 = 3000; exp_s2 = 3;
    exp_p3 = 2000; exp_s3 = 5;
`endif
    do_reset();
    rise_hold();
    step(5000 - 20);
    rise_hold();
    check("seq1 period", int'(period), 5000);
    check("seq1 speed", int'(speed), 1);
    check("seq1 measuring", int'(measuring), 1);
    step(3000 - 20);
    rise_hold();
    check("seq2 period", int'(period), exp_p2);
    check("seq2 speed", int'(speed), exp_s2);
    step(2000 - 20);

    // Final tap: watch for its speed_valid, then count to timeout.
    to0 = to_count;
    tap = 1'b1;
    k = 0;
    while (!speed_valid && k < 10) begin
      step(1);
      k++;
    end
    check("seq3 speed_valid seen", int'(speed_valid), 1);
    check("seq3 period", int'(period), exp_p3);
    check("seq3 speed", int'(speed), exp_s3);
    k = 0;
    while (!timeout && k < 20000) begin
      step(1);
      k++;
      if (k == 20) tap = 1'b0;
    end
    check("timeout latency from edge", k, 10000);
    step(1);
    check("timeout single cycle", int'(timeout), 0);
    check("timeout measuring", int'(measuring), 0);
    check("timeout speed kept", int'(speed), exp_s3);
    check("timeout period kept", int'(period), exp_p3);
    check("timeout pulse count", to_count - to0, 1);

    // Single tap from IDLE starts a count but gives no update.
    sv0 = sv_count;
    rise_hold();
    step(30);
    check("single tap measuring", int'(measuring), 1);
    check("single tap no speed_valid", sv_count - sv0, 0);

    // Reset at +2000 mid-count discards the interval.
    step(2000 - 50);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid reset measuring", int'(measuring), 0);
    check("mid reset speed", int'(speed), 1);
    check("mid reset period", int'(period), 0);
    to0 = to_count;
    step(10500);
    check("mid reset no timeout", to_count - to0, 0);
    check("mid reset no speed_valid", sv_count - sv0, 0);
    check("mid reset stays idle", int'(measuring), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
